// File: rtl/id_hazard_unit.sv
// Decode-stage hazard controller: load-use stall, branch flush and MD-busy hold.
// Optional stall performance counter is built when HAZARD_STALL_CNT_EN is defined.
module id_hazard_unit #(
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_write_reg_addr,
  input  logic [4:0]  if_id_instr_rs,
  input  logic [4:0]  if_id_instr_rt,
  input  logic        if_id_uses_rt,
  input  logic        if_id_md_op,
  input  logic        id_ex_md_start,
  input  logic        ex_branch_taken,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam logic [7:0] MD_RELOAD = 8'(MD_LATENCY - 1);

  state_t     r_state;
  logic [7:0] r_md_cnt;
  logic       w_load_haz;
  logic       w_md_haz;

  // A start always reloads; a start during MD_WAIT restarts the countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= 8'd0;
      r_state  <= RUN;
    end else if (id_ex_md_start) begin
      r_md_cnt <= MD_RELOAD;
      r_state  <= (MD_RELOAD != 8'd0) ? MD_WAIT : RUN;
    end else begin
      case (r_state)
        MD_WAIT: begin
          r_md_cnt <= r_md_cnt - 8'd1;
          r_state  <= (r_md_cnt == 8'd1) ? RUN : MD_WAIT;
        end
        default: begin
          r_md_cnt <= 8'd0;
          r_state  <= RUN;
        end
      endcase
    end
  end

  assign md_busy = (r_state == MD_WAIT);

  assign w_load_haz = id_ex_mem_read && (id_ex_write_reg_addr != 5'd0) &&
                      ((id_ex_write_reg_addr == if_id_instr_rs) ||
                       (if_id_uses_rt && (id_ex_write_reg_addr == if_id_instr_rt)));

  assign w_md_haz = md_busy & if_id_md_op;

  // Branch flush beats any stall: the stalled instruction is on the wrong path.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (w_load_haz || w_md_haz) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 32'd0;
    end else if (!pc_write) begin
      r_stall_cycles <= sat_inc(r_stall_cycles);
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule
